// File: rtl/shake_ctrl_if.sv
// shake_ctrl_if: message-in and output-word valid/ready handshakes of shake_ctrl
interface shake_ctrl_if #(parameter int PARALLEL_SLICES = 16);
  logic [PARALLEL_SLICES-1:0] msg_data;
  logic msg_valid;
  logic msg_last;
  logic msg_ready;
  logic out_valid;
  logic out_ready;
  modport master (output msg_data, msg_valid, msg_last, out_ready, input msg_ready, out_valid);
  modport slave (input msg_data, msg_valid, msg_last, out_ready, output msg_ready, out_valid);
endinterface

// File: rtl/shake_ctrl.sv
// shake_ctrl: SHAKE128/256 sequencing FSM for the sliced Keccak data path; SHAKE_CTRL_ZEROFILL_EN zero-fills blocks cut short by msg_last
module shake_ctrl #(
  parameter int PARALLEL_SLICES = 16,
  parameter int NUM_SUB_ROUNDS = 4,
  parameter int KECCAK_ROUNDS = 24,
  parameter int WOUT = 32,
  parameter int OUT_LEN_W = 16,
  localparam int ROUND_MAX = (KECCAK_ROUNDS + 1) * NUM_SUB_ROUNDS - 1,
  localparam int ROUND_COUNT_WIDTH = $clog2(ROUND_MAX + 1),
  localparam int COUNTER_WIDTH = $clog2(21 * NUM_SUB_ROUNDS + 1)
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic mode256,
  input logic [OUT_LEN_W-1:0] out_words,
  shake_ctrl_if.slave bus,
  output logic [PARALLEL_SLICES-1:0] dp_din,
  output logic dp_absorb_data,
  output logic dp_computation_en,
  output logic dp_squeeze_output,
  output logic dp_bof,
  output logic dp_reset_ram,
  output logic dp_mux256,
  output logic [ROUND_COUNT_WIDTH-1:0] dp_round,
  output logic [COUNTER_WIDTH-1:0] dp_reads,
  output logic busy,
  output logic done,
  output logic err
);
  localparam logic [COUNTER_WIDTH-1:0] BLK128 = COUNTER_WIDTH'(21 * NUM_SUB_ROUNDS);
  localparam logic [COUNTER_WIDTH-1:0] BLK256 = COUNTER_WIDTH'(17 * NUM_SUB_ROUNDS);
  localparam logic [COUNTER_WIDTH-1:0] GMASK = COUNTER_WIDTH'(WOUT / PARALLEL_SLICES - 1);
  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
  typedef enum logic [2:0] {IDLE, CLEAR, ABSORB, FILL, PERMUTE, SQUEEZE, DONE} state_t;
`ifdef SHAKE_CTRL_ZEROFILL_EN
  localparam state_t EARLY = FILL;
`else
  localparam state_t EARLY = IDLE;
`endif
  state_t state, state_n;
  logic mode_q, first, pending, ov;
  logic [OUT_LEN_W-1:0] remaining;
  logic [ROUND_COUNT_WIDTH-1:0] round;
  logic [COUNTER_WIDTH-1:0] reads, blk;
  logic take, last_word, round_end, accept, advance, grp_end, blk_end, finish, release_ok;
  assign blk = mode_q ? BLK256 : BLK128;
  assign take = state == ABSORB && bus.msg_valid;
  assign last_word = reads == blk - ONE;
  assign round_end = round == ROUND_COUNT_WIDTH'(ROUND_MAX);
  assign accept = ov && bus.out_ready;
  assign release_ok = !ov || bus.out_ready;
  assign blk_end = reads == blk;
  assign advance = state == SQUEEZE && !blk_end && release_ok;
  assign grp_end = (reads & GMASK) == GMASK;
  assign finish = accept && remaining == OUT_LEN_W'(1);
  always_ff @(posedge clk) state <= !rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? CLEAR : IDLE;
      CLEAR: state_n = ABSORB;
      ABSORB: state_n = !take ? ABSORB : last_word ? PERMUTE : bus.msg_last ? EARLY : ABSORB;
      FILL: state_n = last_word ? PERMUTE : FILL;
      PERMUTE: state_n = !round_end ? PERMUTE : pending ? ABSORB : SQUEEZE;
      SQUEEZE: state_n = finish ? DONE : blk_end && release_ok ? PERMUTE : SQUEEZE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= 1'b0;
      first <= 1'b0;
      pending <= 1'b0;
      ov <= 1'b0;
      remaining <= '0;
      round <= '0;
      reads <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q <= mode256;
        remaining <= out_words == '0 ? OUT_LEN_W'(1) : out_words;
        err <= 1'b0;
      end
      if (state == CLEAR) first <= 1'b1;
      if (take && last_word) begin
        first <= 1'b0;
        pending <= !bus.msg_last;
      end
      if (state == FILL && last_word) begin
        first <= 1'b0;
        pending <= 1'b0;
      end
`ifndef SHAKE_CTRL_ZEROFILL_EN
      if (take && !last_word && bus.msg_last) err <= 1'b1;
`endif
      if (state_n != state && state_n != FILL) reads <= '0;
      else if (take || state == FILL || advance) reads <= reads + ONE;
      round <= state == PERMUTE && !round_end ? round + ROUND_COUNT_WIDTH'(1) : '0;
      ov <= state_n == SQUEEZE && ((advance && grp_end) || (ov && !bus.out_ready));
      if (accept) remaining <= remaining - OUT_LEN_W'(1);
    end
  end
  always_comb begin
    dp_absorb_data = take || state == FILL;
    dp_din = take ? bus.msg_data : '0;
    dp_bof = first && (take || state == FILL);
    dp_computation_en = state == PERMUTE;
    dp_squeeze_output = state == SQUEEZE;
    dp_reset_ram = state == CLEAR;
    dp_mux256 = mode_q;
    dp_round = round;
    dp_reads = reads;
    bus.msg_ready = state == ABSORB;
    bus.out_valid = ov;
    busy = state != IDLE;
    done = state == DONE;
  end
endmodule

// File: tb/tb_shake_ctrl.sv
// tb_shake_ctrl: directed self-checking bench for shake_ctrl
module tb_shake_ctrl;
  localparam int PS = 16;
  localparam int CLR = 0, ABS = 1, BOF = 2, PRM = 3, WRD = 4, DON = 5, ZRO = 6, RZ = 7, MUX = 8, BSY = 9;
  logic clk, rst, start, mode256;
  logic [15:0] out_words;
  logic [PS-1:0] dp_din;
  logic dp_absorb_data, dp_computation_en, dp_squeeze_output, dp_bof, dp_reset_ram, dp_mux256;
  logic [6:0] dp_round, dp_reads;
  logic busy, done, err;
  int checks = 0, failures = 0;
  int cnt[10] = '{default: 0};
  int base[10] = '{default: 0};
  int cfg_gap, cfg_stall_idx, cfg_stall_len, cfg_stall_reads, cfg_restart_at, cfg_stop_round;
  int acc, stalled, stall_hits, stop_hit, ended;
  shake_ctrl_if #(.PARALLEL_SLICES(PS)) bus ();
  shake_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mode256(mode256), .out_words(out_words), .bus(bus),
    .dp_din(dp_din), .dp_absorb_data(dp_absorb_data), .dp_computation_en(dp_computation_en),
    .dp_squeeze_output(dp_squeeze_output), .dp_bof(dp_bof), .dp_reset_ram(dp_reset_ram),
    .dp_mux256(dp_mux256), .dp_round(dp_round), .dp_reads(dp_reads), .busy(busy), .done(done), .err(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #2;
    cnt[CLR] += int'(dp_reset_ram);
    cnt[ABS] += int'(dp_absorb_data);
    cnt[BOF] += int'(dp_bof);
    cnt[PRM] += int'(dp_computation_en);
    cnt[WRD] += int'(bus.out_valid && bus.out_ready);
    cnt[DON] += int'(done);
    cnt[ZRO] += int'(dp_absorb_data && !bus.msg_ready && dp_din == '0);
    cnt[RZ] += int'(dp_absorb_data && dp_reads == '0);
    cnt[MUX] += int'(busy && dp_mux256);
    cnt[BSY] += int'(busy);
  end
  function automatic int dl(input int i);
    return cnt[i] - base[i];
  endfunction
  task automatic cfg_default();
    cfg_gap = 0; cfg_stall_idx = -1; cfg_stall_len = 0; cfg_stall_reads = -1; cfg_restart_at = -1; cfg_stop_round = -1;
  endtask
  task automatic drive_hash(input logic m, input int nwords, input int outw);
    int sent;
    sent = 0; acc = 0; stalled = 0; stall_hits = 0; stop_hit = 0; ended = 0;
    base = cnt;
    @(negedge clk);
    for (int c = 0; c < 4000 && ended == 0; c++) begin
      mode256 = m;
      out_words = 16'(outw);
      start = c == 0 || c == cfg_restart_at;
      bus.msg_valid = sent < nwords && !(cfg_gap > 0 && c % cfg_gap == cfg_gap - 1);
      bus.msg_data = PS'(sent + 1);
      bus.msg_last = sent == nwords - 1;
      bus.out_ready = 1'b1;
      if (bus.out_valid && acc == cfg_stall_idx && stalled < cfg_stall_len) begin
        bus.out_ready = 1'b0;
        stalled++;
        stall_hits += int'(dp_reads == 7'(cfg_stall_reads));
      end
      #1;
      sent += int'(bus.msg_valid && bus.msg_ready);
      acc += int'(bus.out_valid && bus.out_ready);
      if ((c > 0 && !busy) || (dp_computation_en && dp_round == 7'(cfg_stop_round))) begin
        stop_hit = int'(dp_computation_en);
        ended = 1;
      end else @(negedge clk);
    end
    #3;
    start = 1'b0; bus.msg_valid = 1'b0; bus.msg_last = 1'b0; bus.out_ready = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b0; start = 1'b0; mode256 = 1'b1; out_words = 16'd5;
    bus.msg_valid = 1'b1; bus.msg_data = 16'hABCD; bus.msg_last = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if ({done, err, bus.msg_ready, bus.out_valid} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {done, err, bus.msg_ready, bus.out_valid}); end
    checks++; if ({dp_absorb_data, dp_computation_en, dp_squeeze_output, dp_bof, dp_reset_ram, dp_mux256} !== 6'b0) begin failures++; $display("FAIL reset_dp_ctrl got=%b want=000000", {dp_absorb_data, dp_computation_en, dp_squeeze_output, dp_bof, dp_reset_ram, dp_mux256}); end
    checks++; if ({dp_din, dp_round, dp_reads} !== 30'b0) begin failures++; $display("FAIL reset_dp_bus got=%h/%0d/%0d want=0/0/0", dp_din, dp_round, dp_reads); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({busy, bus.msg_ready, dp_absorb_data} !== 3'b0) begin failures++; $display("FAIL idle_no_consume got=%b want=000", {busy, bus.msg_ready, dp_absorb_data}); end
    bus.msg_valid = 1'b0;
  endtask
  task automatic test_shake128_block();
    cfg_default(); cfg_restart_at = 50;
    drive_hash(1'b0, 84, 8);
    checks++; if (ended !== 1) begin failures++; $display("FAIL s128_timeout got=%0d want=1", ended); end
    checks++; if (dl(CLR) !== 1) begin failures++; $display("FAIL s128_clear got=%0d want=1", dl(CLR)); end
    checks++; if (dl(ABS) !== 84) begin failures++; $display("FAIL s128_absorb got=%0d want=84", dl(ABS)); end
    checks++; if (dl(BOF) !== 84) begin failures++; $display("FAIL s128_bof got=%0d want=84", dl(BOF)); end
    checks++; if (dl(PRM) !== 100) begin failures++; $display("FAIL s128_permute got=%0d want=100", dl(PRM)); end
    checks++; if (dl(WRD) !== 8) begin failures++; $display("FAIL s128_words got=%0d want=8", dl(WRD)); end
    checks++; if (dl(DON) !== 1) begin failures++; $display("FAIL s128_done got=%0d want=1", dl(DON)); end
    checks++; if (dl(BSY) !== 203) begin failures++; $display("FAIL s128_busy_cycles got=%0d want=203", dl(BSY)); end
    checks++; if (dl(MUX) !== 0) begin failures++; $display("FAIL s128_mux256 got=%0d want=0", dl(MUX)); end
    checks++; if ({busy, done, err} !== 3'b0) begin failures++; $display("FAIL s128_end_state got=%b want=000", {busy, done, err}); end
  endtask
  task automatic test_shake256_two_blocks();
    cfg_default();
    drive_hash(1'b1, 136, 4);
    checks++; if (dl(ABS) !== 136) begin failures++; $display("FAIL s256_absorb got=%0d want=136", dl(ABS)); end
    checks++; if (dl(BOF) !== 68) begin failures++; $display("FAIL s256_bof got=%0d want=68", dl(BOF)); end
    checks++; if (dl(RZ) !== 2) begin failures++; $display("FAIL s256_reads_wrap got=%0d want=2", dl(RZ)); end
    checks++; if (dl(PRM) !== 200) begin failures++; $display("FAIL s256_permute got=%0d want=200", dl(PRM)); end
    checks++; if (dl(WRD) !== 4) begin failures++; $display("FAIL s256_words got=%0d want=4", dl(WRD)); end
    checks++; if (dl(MUX) !== 347) begin failures++; $display("FAIL s256_mux256 got=%0d want=347", dl(MUX)); end
    checks++; if (dl(BSY) !== 347) begin failures++; $display("FAIL s256_busy_cycles got=%0d want=347", dl(BSY)); end
  endtask
  task automatic test_backpressure();
    cfg_default(); cfg_stall_idx = 2; cfg_stall_len = 5; cfg_stall_reads = 6;
    drive_hash(1'b0, 84, 8);
    checks++; if (stalled !== 5) begin failures++; $display("FAIL bp_held got=%0d want=5", stalled); end
    checks++; if (stall_hits !== 5) begin failures++; $display("FAIL bp_reads_frozen got=%0d want=5", stall_hits); end
    checks++; if (acc !== 8) begin failures++; $display("FAIL bp_accepted got=%0d want=8", acc); end
    checks++; if (dl(BSY) !== 208) begin failures++; $display("FAIL bp_busy_cycles got=%0d want=208", dl(BSY)); end
    checks++; if (dl(DON) !== 1) begin failures++; $display("FAIL bp_done got=%0d want=1", dl(DON)); end
  endtask
  task automatic test_multi_squeeze();
    cfg_default();
    drive_hash(1'b0, 84, 50);
    checks++; if (dl(PRM) !== 200) begin failures++; $display("FAIL ms_permute got=%0d want=200", dl(PRM)); end
    checks++; if (acc !== 50) begin failures++; $display("FAIL ms_words got=%0d want=50", acc); end
    checks++; if (dl(BSY) !== 388) begin failures++; $display("FAIL ms_busy_cycles got=%0d want=388", dl(BSY)); end
    checks++; if (dl(DON) !== 1) begin failures++; $display("FAIL ms_done got=%0d want=1", dl(DON)); end
  endtask
  task automatic test_early_last();
    cfg_default();
    drive_hash(1'b0, 10, 2);
`ifdef SHAKE_CTRL_ZEROFILL_EN
    checks++; if (dl(ABS) !== 84) begin failures++; $display("FAIL el_absorb got=%0d want=84", dl(ABS)); end
    checks++; if (dl(ZRO) !== 74) begin failures++; $display("FAIL el_zero_fill got=%0d want=74", dl(ZRO)); end
    checks++; if (dl(PRM) !== 100) begin failures++; $display("FAIL el_permute got=%0d want=100", dl(PRM)); end
    checks++; if (dl(DON) !== 1) begin failures++; $display("FAIL el_done got=%0d want=1", dl(DON)); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL el_err got=%b want=0", err); end
    checks++; if (dl(BSY) !== 191) begin failures++; $display("FAIL el_busy_cycles got=%0d want=191", dl(BSY)); end
`else
    checks++; if (dl(ABS) !== 10) begin failures++; $display("FAIL el_absorb got=%0d want=10", dl(ABS)); end
    checks++; if (dl(PRM) !== 0) begin failures++; $display("FAIL el_permute got=%0d want=0", dl(PRM)); end
    checks++; if (dl(DON) !== 0) begin failures++; $display("FAIL el_done got=%0d want=0", dl(DON)); end
    checks++; if ({err, busy} !== 2'b10) begin failures++; $display("FAIL el_err_idle got=%b want=10", {err, busy}); end
    checks++; if (dl(BSY) !== 11) begin failures++; $display("FAIL el_busy_cycles got=%0d want=11", dl(BSY)); end
`endif
  endtask
  task automatic test_zero_words();
    cfg_default();
    drive_hash(1'b1, 68, 0);
    checks++; if (dl(WRD) !== 1) begin failures++; $display("FAIL zw_words got=%0d want=1", dl(WRD)); end
    checks++; if (dl(BSY) !== 173) begin failures++; $display("FAIL zw_busy_cycles got=%0d want=173", dl(BSY)); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL zw_err_cleared got=%b want=0", err); end
  endtask
  task automatic test_reset_mid_permute();
    cfg_default(); cfg_gap = 3; cfg_stop_round = 37;
    drive_hash(1'b0, 84, 8);
    checks++; if (stop_hit !== 1) begin failures++; $display("FAIL rmp_reached got=%0d want=1", stop_hit); end
    checks++; if (dl(ABS) !== 84) begin failures++; $display("FAIL rmp_gap_absorb got=%0d want=84", dl(ABS)); end
    checks++; if (dl(PRM) !== 38) begin failures++; $display("FAIL rmp_permute got=%0d want=38", dl(PRM)); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++; if ({busy, done, err, bus.msg_ready, bus.out_valid, dp_absorb_data, dp_computation_en, dp_squeeze_output, dp_bof, dp_reset_ram, dp_mux256} !== 11'b0) begin failures++; $display("FAIL rmp_ctrl_zero got=%b want=0", {busy, done, err, bus.msg_ready, bus.out_valid, dp_absorb_data, dp_computation_en, dp_squeeze_output, dp_bof, dp_reset_ram, dp_mux256}); end
    checks++; if ({dp_round, dp_reads} !== 14'b0) begin failures++; $display("FAIL rmp_counters_zero got=%0d/%0d want=0/0", dp_round, dp_reads); end
    rst = 1'b1;
    cfg_default();
    drive_hash(1'b1, 68, 2);
    checks++; if (dl(CLR) !== 1) begin failures++; $display("FAIL rmp_fresh_clear got=%0d want=1", dl(CLR)); end
    checks++; if (dl(BOF) !== 68) begin failures++; $display("FAIL rmp_fresh_bof got=%0d want=68", dl(BOF)); end
    checks++; if (dl(PRM) !== 100) begin failures++; $display("FAIL rmp_fresh_permute got=%0d want=100", dl(PRM)); end
    checks++; if (dl(WRD) !== 2) begin failures++; $display("FAIL rmp_fresh_words got=%0d want=2", dl(WRD)); end
    checks++; if (dl(BSY) !== 175) begin failures++; $display("FAIL rmp_fresh_busy_cycles got=%0d want=175", dl(BSY)); end
  endtask
  initial begin
    test_reset();
    test_shake128_block();
    test_shake256_two_blocks();
    test_backpressure();
    test_multi_squeeze();
    test_early_last();
    test_zero_words();
    test_reset_mid_permute();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shake_ctrl.md
Name: shake_ctrl

Overview:
- Sequencing FSM for the sliced SHAKE128/256 data path.
- Accepts padded message words over a valid/ready handshake and drives the data path control inputs: round, reads, bof, absorb_data, computation_en, squeeze_output, reset_ram, mux256, din.
- Runs the Keccak-f permutations and paces squeezed output words to a downstream consumer with backpressure.
- Sits between the HQC sampler/hash wrappers and data_path.

Parameters:
- PARALLEL_SLICES, 16, din width; bits per lane per read.
- NUM_SUB_ROUNDS, 4, reads per 64-bit lane (64/PARALLEL_SLICES); power of 2.
- KECCAK_ROUNDS, 24, permutation rounds.
- WOUT, 32, data path output word width; WOUT/PARALLEL_SLICES reads per output word.
- OUT_LEN_W, 16, width of the requested output-word count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle pulse; begins a hash when idle.
- mode256  in  1  0 = SHAKE128 (21 rate lanes), 1 = SHAKE256 (17 rate lanes); sampled on start.
- out_words  in  OUT_LEN_W  number of WOUT words to squeeze; sampled on start; 0 treated as 1.
- msg_data  in  PARALLEL_SLICES  padded message word.
- msg_valid  in  1  msg_data valid.
- msg_last  in  1  final word of the message.
- msg_ready  out  1  controller accepts msg_data this cycle.
- dp_din  out  PARALLEL_SLICES  data path din.
- dp_absorb_data, dp_computation_en, dp_squeeze_output, dp_bof, dp_reset_ram, dp_mux256  out  1 each  data path controls.
- dp_round  out  ROUND_COUNT_WIDTH  round/sub-round counter.
- dp_reads  out  COUNTER_WIDTH  read/absorb counter.
- out_valid  out  1  data path dout holds a valid output word.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last output word is accepted.
- err  out  1  sticky protocol error; cleared by start or reset.

Behaviour:
- Reset (rst=0 at a clk edge) forces IDLE from any state, mid-operation included. All outputs and counters become 0.
- BLK = (mode256 ? 17 : 21) * NUM_SUB_ROUNDS words per block: 68 for SHAKE256, 84 for SHAKE128.
- dp_mux256 = latched mode256 for the whole hash.

States:
- IDLE: busy=0. On start, latch mode256 and out_words, clear err, go to CLEAR. A start pulse in any other state is ignored.
- CLEAR: dp_reset_ram=1 for exactly 1 cycle. Set first-block flag; reads=0. Go to ABSORB.
- ABSORB: msg_ready=1. On each msg_valid&msg_ready: dp_absorb_data=1, dp_din=msg_data, dp_bof=first-block flag, then reads++. When msg_valid=0: absorb_data=0 and reads holds. At reads==BLK-1 accepted: go to PERMUTE, clear first-block flag, remember msg_last.
- Early msg_last (reads<BLK-1): handled per Optional Feature.
- PERMUTE: dp_computation_en=1; round counts 0..(KECCAK_ROUNDS+1)*NUM_SUB_ROUNDS-1 (0..99 at defaults), one step per cycle. After the final count:
  - more message pending -> ABSORB, reads=0;
  - otherwise -> SQUEEZE, reads=0.
- SQUEEZE:
  - dp_squeeze_output=1.
  - reads advances only while the current word is not stalled: out_valid=0, or out_valid&out_ready.
  - out_valid asserts the cycle after reads completes a WOUT group, i.e. reads[log2(WOUT/PARALLEL_SLICES)-1:0] all-ones. It holds while out_ready=0, and reads must not advance past the held word.
  - Each accepted word decrements the remaining count.
  - Remaining==0 -> DONE.
  - reads reaching BLK with words remaining -> PERMUTE (reads=0, round=0), then SQUEEZE again.
- DONE: done=1 for 1 cycle, then IDLE.

Simultaneous events:
- out_ready with a stall release: the word is accepted and reads advances in the same cycle.
- msg_valid in states other than ABSORB: msg_ready=0 and the word is not consumed.

Optional Feature:
- Macro SHAKE_CTRL_ZEROFILL_EN.
- Defined: early msg_last makes the controller finish the block itself. msg_ready drops to 0, and dp_absorb_data=1 continues with dp_din=0 each cycle until reads==BLK-1. It then permutes and squeezes; err stays 0.
- Undefined: early msg_last sets err=1. The word is still absorbed. The FSM goes to IDLE without permuting, no done pulse.

Test Plan:
- SHAKE128, one block: 84 words, msg_last on word 84, out_words=8, out_ready=1 -> 1 reset_ram cycle, 84 absorb cycles with bof=1, 100 permute cycles, 8 out_valid pulses, done=1, busy=0.
- SHAKE256, 2 blocks (136 words) -> 2 permutes; bof=1 only for words 0..67; reads wraps at 68.
- Squeeze backpressure: out_ready low 5 cycles on word 3 -> out_valid held, dp_reads frozen; exactly 8 words accepted in order.
- out_words=50 with SHAKE128 (42 words/block) -> a second PERMUTE after 42 words, then 8 more words, done.
- msg_valid gaps plus rst=0 mid-PERMUTE (round=37) -> next cycle IDLE, all outputs 0; a subsequent start behaves as fresh.
- Early msg_last at word 10 -> ZEROFILL_EN: 74 zero-din absorb cycles, then permute; without it: err=1, IDLE, no done.
